// File: rtl/traffic_pkg.sv
// Shared types for the intersection phase controller: phase encoding and
// round-robin side stepping.
package traffic_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        AMBER   = 2'd2
    } phase_e;

    // Sides are carried as 5 bits so that n=16 is representable.
    function automatic logic [4:0] next_side(input logic [4:0] side, input logic [4:0] n);
        return (side >= n - 5'd1) ? 5'd0 : side + 5'd1;
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_phase_timer.sv
// Tick-gated phase down-counter: a load wins over counting, a hold freezes the
// count, and counting stops at zero until the owner reloads.
module phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_tick,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_hold,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_tick && !i_hold && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-way round-robin green/amber/all-red phase sequencer with per-side density
// selected green length. Define PREEMPT_EN to add the pre_req/pre_side/pre_ack preemption path.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter  int N_SIDES    = 4,
    parameter  int CNT_W      = 8,
    parameter  int GREEN_LOW  = 10,
    parameter  int GREEN_HIGH = 30,
    parameter  int AMBER_T    = 4,
    parameter  int ALLRED_T   = 2,
    localparam int SW         = (N_SIDES > 1) ? $clog2(N_SIDES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic [N_SIDES-1:0] density,
    output logic [SW-1:0]      side_o,
    output logic [N_SIDES-1:0] green_o,
    output logic [N_SIDES-1:0] amber_o,
    output logic [N_SIDES-1:0] red_o,
`ifdef PREEMPT_EN
    input  logic               pre_req,
    input  logic [SW-1:0]      pre_side,
    output logic               pre_ack,
`endif
    output logic [1:0]         phase_o
);

    localparam logic [CNT_W-1:0]   L_GREEN_LO = CNT_W'(GREEN_LOW - 1);
    localparam logic [CNT_W-1:0]   L_GREEN_HI = CNT_W'(GREEN_HIGH - 1);
    localparam logic [CNT_W-1:0]   L_AMBER    = CNT_W'(AMBER_T - 1);
    localparam logic [CNT_W-1:0]   L_ALLRED   = CNT_W'(ALLRED_T - 1);
    localparam logic [4:0]         L_NSIDES   = 5'(N_SIDES);
    localparam logic [N_SIDES-1:0] L_ONE      = N_SIDES'(1);

    phase_e               r_state;
    logic [SW-1:0]        r_side;
    logic [N_SIDES-1:0]   r_green;
    logic [N_SIDES-1:0]   r_amber;

    logic                 w_pre_valid;
    logic [SW-1:0]        w_pre_side;
    logic                 w_force;
    logic                 w_hold;
    logic                 w_expire;
    logic                 w_load;
    logic [CNT_W-1:0]     w_load_val;
    logic [CNT_W-1:0]     w_cnt;
    logic                 w_zero;
    logic [SW-1:0]        w_green_side;
    logic [SW-1:0]        w_next_side;

`ifdef PREEMPT_EN
    // Requests naming a nonexistent side are dropped entirely.
    assign w_pre_valid = pre_req && (int'(pre_side) < N_SIDES);
    assign w_pre_side  = pre_side;
    assign pre_ack     = w_hold;
`else
    assign w_pre_valid = 1'b0;
    assign w_pre_side  = '0;
`endif

    assign w_force      = (r_state == GREEN) && w_pre_valid && (r_side != w_pre_side);
    assign w_hold       = (r_state == GREEN) && w_pre_valid && (r_side == w_pre_side);
    assign w_expire     = tick && w_zero && !w_hold;
    assign w_load       = w_force || w_expire;
    assign w_green_side = w_pre_valid ? w_pre_side : r_side;
    assign w_next_side  = w_pre_valid ? w_pre_side : SW'(next_side(5'(r_side), L_NSIDES));

    always_comb begin
        w_load_val = L_ALLRED;
        case (r_state)
            ALL_RED: w_load_val = density[w_green_side] ? L_GREEN_HI : L_GREEN_LO;
            GREEN:   w_load_val = L_AMBER;
            AMBER:   w_load_val = L_ALLRED;
            default: w_load_val = L_ALLRED;
        endcase
    end

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (L_ALLRED)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_tick     (tick),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_hold     (w_hold),
        .o_cnt      (w_cnt),
        .o_zero     (w_zero)
    );

    // Lamps are registered alongside the state so they switch on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ALL_RED;
            r_side  <= '0;
            r_green <= '0;
            r_amber <= '0;
        end else if (w_load) begin
            case (r_state)
                ALL_RED: begin
                    r_state <= GREEN;
                    r_side  <= w_green_side;
                    r_green <= L_ONE << w_green_side;
                    r_amber <= '0;
                end
                GREEN: begin
                    r_state <= AMBER;
                    r_green <= '0;
                    r_amber <= L_ONE << r_side;
                end
                AMBER: begin
                    r_state <= ALL_RED;
                    r_side  <= w_next_side;
                    r_green <= '0;
                    r_amber <= '0;
                end
                default: begin
                    r_state <= ALL_RED;
                    r_side  <= '0;
                    r_green <= '0;
                    r_amber <= '0;
                end
            endcase
        end
    end

    assign side_o  = r_side;
    assign green_o = r_green;
    assign amber_o = r_amber;
    assign red_o   = ~(r_green | r_amber);
    assign phase_o = r_state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomised bench for traffic_phase_ctrl (4-side and 3-side instances) against
// a remaining-ticks reference model of the phase rotation.
module tb_traffic_phase_ctrl;

    localparam int GL = 10;
    localparam int GH = 30;
    localparam int AT = 4;
    localparam int AR = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] dens_a = '0;
    logic [2:0] dens_b = '0;

    logic [1:0] a_side, a_phase, b_side, b_phase;
    logic [3:0] a_green, a_amber, a_red;
    logic [2:0] b_green, b_amber, b_red;
`ifdef PREEMPT_EN
    logic       pre_req = 1'b0;
    logic [1:0] pre_side = '0;
    logic       pre_ack;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model state: phase (0/1/2), side, ticks remaining in phase.
    int ma_ph, ma_sd, ma_rem, mb_ph, mb_sd, mb_rem;
    int last_ga, last_gb, prev_pha, prev_phb;

    always #5 clk = ~clk;

    traffic_phase_ctrl u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .density (dens_a),
        .side_o  (a_side),
        .green_o (a_green),
        .amber_o (a_amber),
        .red_o   (a_red),
`ifdef PREEMPT_EN
        .pre_req (pre_req),
        .pre_side(pre_side),
        .pre_ack (pre_ack),
`endif
        .phase_o (a_phase)
    );

    traffic_phase_ctrl #(.N_SIDES(3)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .density (dens_b),
        .side_o  (b_side),
        .green_o (b_green),
        .amber_o (b_amber),
        .red_o   (b_red),
`ifdef PREEMPT_EN
        .pre_req (1'b0),
        .pre_side(2'd0),
        .pre_ack (),
`endif
        .phase_o (b_phase)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ma_ph = 0; ma_sd = 0; ma_rem = AR;
        mb_ph = 0; mb_sd = 0; mb_rem = AR;
        last_ga = -1; last_gb = -1; prev_pha = 0; prev_phb = 0;
    endtask

    task automatic model_step(input int n, input bit tk, input logic [15:0] d,
                              inout int ph, inout int sd, inout int rem);
        if (tk) begin
            rem--;
            if (rem == 0) begin
                case (ph)
                    0: begin ph = 1; rem = d[sd] ? GH : GL; end
                    1: begin ph = 2; rem = AT; end
                    default: begin ph = 0; rem = AR; sd = (sd + 1) % n; end
                endcase
            end
        end
    endtask

    function automatic logic [63:0] pack_exp(input int n, input int ph, input int sd);
        logic [15:0] g, a, r;
        g = (ph == 1) ? (16'd1 << sd) : 16'd0;
        a = (ph == 2) ? (16'd1 << sd) : 16'd0;
        r = ~(g | a) & ((16'd1 << n) - 16'd1);
        return {10'd0, 4'(sd), 2'(ph), g, a, r};
    endfunction

    function automatic logic [63:0] pack_obs(input logic [1:0] sd, input logic [1:0] ph,
                                             input logic [15:0] g, input logic [15:0] a,
                                             input logic [15:0] r);
        return {10'd0, 4'(sd), ph, g, a, r};
    endfunction

    task automatic compare_all(input bit chk_a);
        logic [3:0] ra;
        logic [2:0] rb;
        ra = ~(a_green | a_amber);
        rb = ~(b_green | b_amber);
        if (chk_a) begin
            check_eq("A.state", pack_obs(a_side, a_phase, 16'(a_green), 16'(a_amber), 16'(a_red)),
                     pack_exp(4, ma_ph, ma_sd));
            if (a_phase == 2'd1 && prev_pha != 1) begin
                check_eq("A.rr_order", 64'(a_side), 64'((last_ga + 1) % 4));
                last_ga = int'(a_side);
            end
            prev_pha = int'(a_phase);
        end
        check_eq("B.state", pack_obs(b_side, b_phase, 16'(b_green), 16'(b_amber), 16'(b_red)),
                 pack_exp(3, mb_ph, mb_sd));
        if (b_phase == 2'd1 && prev_phb != 1) begin
            check_eq("B.rr_order", 64'(b_side), 64'((last_gb + 1) % 3));
            last_gb = int'(b_side);
        end
        prev_phb = int'(b_phase);
        check_eq("A.onehot", 64'($countones(a_green | a_amber) <= 1), 64'd1);
        check_eq("A.red_compl", 64'(a_red), 64'(ra));
        check_eq("B.onehot", 64'($countones(b_green | b_amber) <= 1), 64'd1);
        check_eq("B.red_compl", 64'(b_red), 64'(rb));
        check_eq("B.side_range", 64'(b_side < 2'd3), 64'd1);
    endtask

    task automatic cycle(input bit tk, input logic [3:0] da, input logic [2:0] db, input bit chk_a);
        @(negedge clk);
        tick = tk;
        dens_a = da;
        dens_b = db;
        @(posedge clk);
        #1;
        model_step(4, tk, 16'(da), ma_ph, ma_sd, ma_rem);
        model_step(3, tk, 16'(db), mb_ph, mb_sd, mb_rem);
        compare_all(chk_a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick = 1'b0;
        #1;
        model_reset();
        check_eq("rst.A_red", 64'(a_red), 64'h0F);
        check_eq("rst.A_green", 64'(a_green), 64'h0);
        check_eq("rst.A_amber", 64'(a_amber), 64'h0);
        check_eq("rst.A_phase_side", 64'({a_phase, a_side}), 64'h0);
        check_eq("rst.B_red", 64'(b_red), 64'h07);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits for the given side to turn green, then counts ticks until it ends.
    task automatic measure_green(input string tag, input logic [3:0] gmask,
                                 input logic [3:0] dens, input int exp_len);
        int n;
        int len;
        n = 0;
        while (a_green !== gmask && n < 300) begin
            cycle(1'b1, dens, 3'd0, 1'b1);
            n++;
        end
        check_eq({tag, "_start"}, 64'(n < 300), 64'd1);
        len = 0;
        while (a_green === gmask && len < 100) begin
            cycle(1'b1, (len >= 5 && len < 12) ? (dens ^ 4'b0100) : dens, 3'd0, 1'b1);
            len++;
        end
        check_eq({tag, "_len"}, 64'(len), 64'(exp_len));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Basic rotation with low density everywhere.
        repeat (2) cycle(1'b1, 4'd0, 3'd0, 1'b1);
        check_eq("seq.green0", 64'(a_green), 64'h1);
        repeat (10) cycle(1'b1, 4'd0, 3'd0, 1'b1);
        check_eq("seq.amber0", 64'({a_green, a_amber}), 64'h01);
        repeat (4) cycle(1'b1, 4'd0, 3'd0, 1'b1);
        check_eq("seq.allred", 64'({a_phase, a_red}), 64'h0F);
        repeat (2) cycle(1'b1, 4'd0, 3'd0, 1'b1);
        check_eq("seq.green1", 64'(a_green), 64'h2);

        // Density-selected lengths; density[2] toggles mid-green.
        measure_green("dens.side2", 4'b0100, 4'b0100, GH);
        measure_green("dens.side3", 4'b1000, 4'b0100, GL);
        measure_green("dens.side0", 4'b0001, 4'b0100, GL);

        // Freeze mid-green, then reset in the middle of amber.
        n = 0;
        while (a_phase !== 2'd1 && n < 100) begin cycle(1'b1, 4'd0, 3'd0, 1'b1); n++; end
        repeat (3) cycle(1'b1, 4'd0, 3'd0, 1'b1);
        repeat (100) cycle(1'b0, 4'($urandom), 3'($urandom), 1'b1);
        n = 0;
        while (a_phase !== 2'd2 && n < 100) begin cycle(1'b1, 4'd0, 3'd0, 1'b1); n++; end
        check_eq("amber.reached", 64'(n < 100), 64'd1);
        cycle(1'b1, 4'd0, 3'd0, 1'b1);
        do_reset();
        repeat (2) cycle(1'b1, 4'd0, 3'd0, 1'b1);
        check_eq("restart.green0", 64'({a_side, a_green}), 64'h01);

        // Random tick and density.
        for (int i = 0; i < 10000; i++) begin
            cycle($urandom_range(0, 2) == 0, 4'($urandom), 3'($urandom), 1'b1);
        end

`ifdef PREEMPT_EN
        do_reset();
        repeat (2) cycle(1'b1, 4'd0, 3'd0, 1'b1);
        check_eq("pre.green0", 64'(a_green), 64'h1);
        pre_req = 1'b1;
        pre_side = 2'd2;
        cycle(1'b0, 4'd0, 3'd0, 1'b0);
        check_eq("pre.amber0", 64'({a_green, a_amber}), 64'h01);
        n = 0;
        while (a_green !== 4'b0100 && n < 30) begin cycle(1'b1, 4'd0, 3'd0, 1'b0); n++; end
        check_eq("pre.green2", 64'({a_green, pre_ack}), 64'h9);
        repeat (50) cycle(1'b1, 4'd0, 3'd0, 1'b0);
        check_eq("pre.held", 64'({a_green, pre_ack}), 64'h9);
        pre_req = 1'b0;
        n = 0;
        while (a_green === 4'b0100 && n < 100) begin
            cycle(1'b1, 4'd0, 3'd0, 1'b0);
            if (n == 0) check_eq("pre.ack_drop", 64'(pre_ack), 64'd0);
            n++;
        end
        check_eq("pre.remaining", 64'(n), 64'(GL));
        n = 0;
        while (a_green === 4'b0000 && n < 30) begin cycle(1'b1, 4'd0, 3'd0, 1'b0); n++; end
        check_eq("pre.next_side3", 64'(a_green), 64'h8);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
